// File: rtl/issue_ctrl_pkg.sv
// Shared constants and types for the in-order issue controller.
// Holds the zero-register index, the IDLE/SPLIT encoding and default sizes.
package issue_ctrl_pkg;

    localparam int REG_ZERO   = 0;
    localparam int DEF_LANES  = 2;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } issue_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Single-pair RAW/WAW comparator: flags a conflict when a younger lane
// depends on, or overwrites the destination of, an older lane.
module hazard_cmp
    import issue_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              i_old_we,
    input  logic [REG_AW-1:0] i_old_rd,
    input  logic              i_new_we,
    input  logic [REG_AW-1:0] i_new_rd,
    input  logic [REG_AW-1:0] i_new_rs,
    input  logic              i_new_rs_use,
    input  logic [REG_AW-1:0] i_new_rt,
    input  logic              i_new_rt_use,
    output logic              o_conflict
);

    logic w_old_writes;
    logic w_raw;
    logic w_waw;

    // Writes to the zero register are discarded, so they never create a dependency.
    assign w_old_writes = i_old_we && (i_old_rd != REG_AW'(REG_ZERO));
    assign w_raw = w_old_writes &&
                   ((i_new_rs_use && (i_new_rs == i_old_rd)) ||
                    (i_new_rt_use && (i_new_rt == i_old_rd)));
    assign w_waw = w_old_writes && i_new_we && (i_new_rd == i_old_rd);
    assign o_conflict = w_raw || w_waw;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: issues the longest hazard-free prefix of a
// decode bundle each cycle and holds the remainder in a pending mask.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_bundle_valid,
    output logic                    o_bundle_ready,
    input  logic [LANES-1:0]        i_lane_valid,
    input  logic [LANES-1:0]        i_lane_we,
    input  logic [LANES*REG_AW-1:0] i_lane_rd,
    input  logic [LANES*REG_AW-1:0] i_lane_rs,
    input  logic [LANES*REG_AW-1:0] i_lane_rt,
    input  logic [LANES-1:0]        i_lane_rs_use,
    input  logic [LANES-1:0]        i_lane_rt_use,
    input  logic                    i_ex_stall,
    input  logic                    i_flush,
    output logic [LANES-1:0]        o_lane_ce,
    output logic [CNT_W-1:0]        o_split_cycles
);

    logic [LANES-1:0] r_pend;
    logic [CNT_W-1:0] r_cnt;

    issue_state_e     w_state;
    logic [LANES-1:0] w_cand;
    logic [LANES-1:0] w_grp;
    logic [LANES-1:0] w_rem;
    logic             w_issue;
    logic             w_blocked;
    logic             w_hit;
    logic             w_conf [LANES][LANES];

    // w_conf[j][i]: younger lane j conflicts with older lane i.
    for (genvar j = 0; j < LANES; j++) begin : g_new
        for (genvar i = 0; i < LANES; i++) begin : g_old
            if (i < j) begin : g_pair
                hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
                    .i_old_we     (i_lane_we[i]),
                    .i_old_rd     (i_lane_rd[i*REG_AW +: REG_AW]),
                    .i_new_we     (i_lane_we[j]),
                    .i_new_rd     (i_lane_rd[j*REG_AW +: REG_AW]),
                    .i_new_rs     (i_lane_rs[j*REG_AW +: REG_AW]),
                    .i_new_rs_use (i_lane_rs_use[j]),
                    .i_new_rt     (i_lane_rt[j*REG_AW +: REG_AW]),
                    .i_new_rt_use (i_lane_rt_use[j]),
                    .o_conflict   (w_conf[j][i])
                );
            end else begin : g_none
                assign w_conf[j][i] = 1'b0;
            end
        end
    end

    assign w_state = (r_pend == '0) ? ST_IDLE : ST_SPLIT;
    assign w_cand  = (w_state == ST_IDLE) ? i_lane_valid : r_pend;

    // Stop at the first candidate that conflicts with anything already chosen;
    // non-candidate lanes are skipped without ending the prefix.
    always_comb begin
        w_grp     = '0;
        w_blocked = 1'b0;
        w_hit     = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            w_hit = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if ((i < j) && w_grp[i] && w_conf[j][i]) begin
                    w_hit = 1'b1;
                end
            end
            if (w_cand[j] && !w_blocked) begin
                if (w_hit) begin
                    w_blocked = 1'b1;
                end else begin
                    w_grp[j] = 1'b1;
                end
            end
        end
    end

    assign w_issue        = i_bundle_valid && !i_ex_stall && !i_flush && !i_rst;
    assign w_rem          = w_cand & ~w_grp;
    assign o_lane_ce      = w_issue ? w_grp : '0;
    assign o_bundle_ready = w_issue && (w_rem == '0);
    assign o_split_cycles = r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_flush) begin
                r_pend <= '0;
            end else if (w_issue) begin
                r_pend <= w_rem;
            end
            if (w_issue && (w_rem != '0) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
